// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a byte FIFO fed by core stores, drained by an 8N1 serialiser.
// Optional even parity bit between data and stop when UART_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq_empty,
  output logic [2:0]  state_dbg
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  localparam logic PARITY_FLAG = 1'b0;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  // Bus-side handshake: a store is a single-cycle strobe (we) with no ready;
  // TXDATA stores are accepted only when count < FIFO_DEPTH, otherwise dropped and flagged.
  logic             sel;
  logic [1:0]       idx;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [7:0]       head;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shreg, shreg_n;
  logic              par, par_n;

  logic unused_bits;
  assign unused_bits = ^{wdata[31:8], wdata[2:0], addr[1:0], BASE_ADDR[3:0]};

  assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign idx      = addr[3:2];
  assign push_req = we && sel && (idx == 2'd0);
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_ok  = push_req && !full;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata[7:0];
  end

  // Count is judged before this edge's pop, so a push into a full FIFO is dropped
  // even when the serialiser frees a slot on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full)
        overflow <= 1'b1;
      else if (we && sel && (idx == 2'd1) && wdata[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      par     <= par_n;
    end
  end

  // Every bit lasts CLK_DIV cycles: reload on entry, advance when baud hits zero.
  always_comb begin
    state_n = state;
    baud_n  = (baud == '0) ? baud : baud - 1'b1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    par_n   = par;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          par_n   = ^head;
          baud_n  = BAUD_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_n  = BAUD_LOAD;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n  = BAUD_LOAD;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud == '0) begin
          baud_n  = BAUD_LOAD;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (baud == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            par_n   = ^head;
            baud_n  = BAUD_LOAD;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
`ifdef UART_PARITY_EN
      PARITY:  txd = par;
`endif
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if (sel && (idx == 2'd1)) begin
      rdata[0]    = full;
      rdata[1]    = empty;
      rdata[2]    = (state != IDLE);
      rdata[3]    = overflow;
      rdata[4]    = PARITY_FLAG;
      rdata[14:8] = 7'(count);
    end
  end

  assign irq_empty = empty && (state == IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vectors plus frame-level sequences checked
// against a bit-sampling receiver model (build with UART_PARITY_EN for the parity variant).
module tb_mmio_uart_tx;

  localparam int CLK_DIV = 16;
  localparam int SAMP    = 12;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PBIT = 32'h10;
`else
  localparam int NB = 10;
  localparam logic [31:0] PBIT = 32'h0;
`endif
  localparam logic [31:0] ST_IDLE = 32'h2 | PBIT;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        txd;
  logic        irq_empty;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8), .BASE_ADDR(32'h0000_1000)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .txd(txd), .irq_empty(irq_empty), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_write;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    check(name, rdata, exp);
    addr = 32'h0;
  endtask

  // Entered at frame offset 'off' (negedges since the start edge); returns at offset NB*CLK_DIV.
  task automatic expect_frame(input logic [7:0] b, input int off, input string tag);
    logic [10:0] bits;
    logic irq_stop;
    bits = '0;
    repeat (SAMP - off) @(negedge clk);
    bits[0] = txd;
    for (int k = 1; k < NB; k++) begin
      repeat (CLK_DIV) @(negedge clk);
      bits[k] = txd;
    end
    irq_stop = irq_empty;
    repeat (CLK_DIV - SAMP) @(negedge clk);
    check({tag, "_start"}, 32'(bits[0]), 32'h0);
    check({tag, "_data"}, 32'(bits[8:1]), 32'(b));
`ifdef UART_PARITY_EN
    check({tag, "_parity"}, 32'(bits[9]), 32'(^b));
`endif
    check({tag, "_stop"}, 32'(bits[NB-1]), 32'h1);
    check({tag, "_irq_busy"}, 32'(irq_stop), 32'h0);
  endtask

  task automatic watch_idle(input int cycles, input string name);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check(name, 32'(lows), 32'h0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0;

    vecs[0] = '{1'b0, 32'h0,      32'h0,  32'h0000_1000, 32'h0};
    vecs[1] = '{1'b0, 32'h0,      32'h0,  32'h0000_1008, 32'h0};
    vecs[2] = '{1'b0, 32'h0,      32'h0,  32'h0000_100C, 32'h0};
    vecs[3] = '{1'b0, 32'h0,      32'h0,  32'h0000_0004, 32'h0};
    vecs[4] = '{1'b1, 32'h2000,   32'h5A, 32'h0000_1004, ST_IDLE};
    vecs[5] = '{1'b1, 32'h1008,   32'hAA, 32'h0000_1004, ST_IDLE};
    vecs[6] = '{1'b1, 32'h1004,   32'hFF, 32'h0000_1004, ST_IDLE};
    vecs[7] = '{1'b1, 32'h100C,   32'h33, 32'h0000_2004, 32'h0};

    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd), 32'h1);
    check("reset_irq", 32'(irq_empty), 32'h1);
    rst = 1'b0;

    // Test 1: idle
    repeat (50) @(negedge clk);
    check("idle_txd", 32'(txd), 32'h1);
    check("idle_irq", 32'(irq_empty), 32'h1);
    read_check(32'h1004, ST_IDLE, "idle_status");

    // Register vectors: reserved/out-of-window accesses never disturb the FIFO
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_write) bus_write(vecs[i].waddr, vecs[i].wdat);
      read_check(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_txd", i), 32'(txd), 32'h1);
    end
    repeat (5) @(negedge clk);

    // Test 2: single byte, exact latency and line-idle timing
    bus_write(32'h1000, 32'h55);
    check("t2_txd_before_pop", 32'(txd), 32'h1);
    @(negedge clk);
    check("t2_txd_after_pop", 32'(txd), 32'h0);
    expect_frame(8'h55, 0, "t2");
    check("t2_end_txd", 32'(txd), 32'h1);
    check("t2_end_irq", 32'(irq_empty), 32'h1);
    repeat (10) @(negedge clk);

    // Test 3: back-to-back frames, no idle gap
    bus_write(32'h1000, 32'h41);
    bus_write(32'h1000, 32'h42);
    expect_frame(8'h41, 0, "t3a");
    check("t3_no_gap", 32'(txd), 32'h0);
    expect_frame(8'h42, 0, "t3b");
    check("t3_end_txd", 32'(txd), 32'h1);
    check("t3_end_irq", 32'(irq_empty), 32'h1);
    repeat (10) @(negedge clk);

    // Test 4: ten stores into an 8-deep FIFO; one pop in between, 10th dropped
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; addr = 32'h1000; wdata = 32'(8'h10 + i);
      @(negedge clk);
    end
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
    read_check(32'h1004, 32'h0000_080D | PBIT, "t4_status_ovf");
    bus_write(32'h1004, 32'h8);
    read_check(32'h1004, 32'h0000_0805 | PBIT, "t4_status_clr");
    for (int i = 0; i < 9; i++)
      expect_frame(8'(8'h10 + i), (i == 0) ? 9 : 0, $sformatf("t4_f%0d", i));
    check("t4_end_irq", 32'(irq_empty), 32'h1);
    watch_idle(200, "t4_no_tenth_frame");
    read_check(32'h1004, ST_IDLE, "t4_status_final");

    // Test 5: reset mid-frame during bit 3 with bytes queued
    bus_write(32'h1000, 32'hF0);
    bus_write(32'h1000, 32'h0F);
    bus_write(32'h1000, 32'h3C);
    repeat (69) @(negedge clk);
    check("t5_bit3_before_rst", 32'(txd), 32'h0);
    rst = 1'b1;
    #1;
    check("t5_txd_async", 32'(txd), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    read_check(32'h1004, ST_IDLE, "t5_status");
    check("t5_irq", 32'(irq_empty), 32'h1);
    watch_idle(300, "t5_no_frames");

`ifdef UART_PARITY_EN
    // Test 6: parity bit and 11-bit frame length
    bus_write(32'h1000, 32'h07);
    @(negedge clk);
    expect_frame(8'h07, 0, "t6a");
    check("t6a_end_txd", 32'(txd), 32'h1);
    check("t6a_end_irq", 32'(irq_empty), 32'h1);
    bus_write(32'h1000, 32'h03);
    @(negedge clk);
    expect_frame(8'h03, 0, "t6b");
    check("t6b_end_irq", 32'(irq_empty), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
